// File: rtl/cp0_exception_commit.sv
// CP0 exception commit: Status/Cause/EPC registers plus the exception-entry
// sequencer (IDLE -> FLUSH -> REDIR) and the single-cycle eret return path.
module cp0_exception_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pendingexception,
  input  logic [4:0]  exccode,
  input  logic [31:0] ex_pc,
  input  logic        ex_bd,
  input  logic [7:0]  hw_int,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        iec,
  output logic        flush,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] REDIR = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  status_q, status_d;
  logic        cause_bd_q, cause_bd_d;
  logic [1:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;
  logic        eret_pend_q, eret_pend_d;
  logic [31:0] eret_pc_q, eret_pc_d;

  // hw_int[1:0] have no Cause field.
  logic unused_hw_bits;
  assign unused_hw_bits = ^hw_int[1:0];

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = cause_ip_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    eret_pend_d = 1'b0;
    eret_pc_d   = eret_pc_q;
    case (state_q)
      IDLE: begin
        if (pendingexception) begin
          epc_d       = ex_bd ? (ex_pc - 32'd4) : ex_pc;
          cause_bd_d  = ex_bd;
          cause_exc_d = exccode;
          status_d    = {status_q[3:0], 2'b00};
          state_d     = FLUSH;
        end else begin
          if (eret) begin
            status_d    = {status_q[5:4], status_q[5:2]};
            eret_pend_d = 1'b1;
            eret_pc_d   = epc_q;
          end
          if (mtc0_we) begin
            case (cp0_addr)
              // The eret pop owns Status when both arrive together.
              5'd12:   if (!eret) status_d = cp0_wdata[5:0];
              5'd13:   cause_ip_d = cp0_wdata[9:8];
              5'd14:   epc_d = cp0_wdata;
              default: ;
            endcase
          end
        end
      end
      FLUSH:   state_d = REDIR;
      REDIR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      status_q    <= 6'd0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 2'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
      eret_pend_q <= 1'b0;
      eret_pc_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
      eret_pend_q <= eret_pend_d;
      eret_pc_q   <= eret_pc_d;
    end
  end

  // Control outputs decode registered state only, never live inputs.
  assign iec      = status_q[0];
  assign flush    = (state_q == FLUSH) | eret_pend_q;
  assign stall    = (state_q == FLUSH) | (state_q == REDIR);
  assign redirect = (state_q == REDIR) | eret_pend_q;

  always_comb begin
    redirect_pc = 32'd0;
    if (state_q == REDIR)
      redirect_pc = EXC_VECTOR;
    else if (eret_pend_q)
      redirect_pc = eret_pc_q;
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      5'd12:   cp0_rdata = {26'd0, status_q};
      5'd13:   cp0_rdata = {cause_bd_q, 15'd0, hw_int[7:2], cause_ip_q, 1'b0, cause_exc_q, 2'b00};
      5'd14:   cp0_rdata = epc_q;
      default: cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception_commit.sv
// Bench for cp0_exception_commit: directed vector table, async-reset abort
// sequence, then randomized traffic against an event-queue reference model.
module tb_cp0_exception_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pendingexception, ex_bd, eret, mtc0_we;
  logic [4:0]  exccode, cp0_addr;
  logic [31:0] ex_pc, cp0_wdata;
  logic [7:0]  hw_int;
  logic [31:0] cp0_rdata, redirect_pc;
  logic        iec, flush, stall, redirect;

  int n_vec = 0;
  int n_bad = 0;

  cp0_exception_commit dut (
    .clk(clk), .reset(reset),
    .pendingexception(pendingexception), .exccode(exccode), .ex_pc(ex_pc),
    .ex_bd(ex_bd), .hw_int(hw_int), .eret(eret), .mtc0_we(mtc0_we),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
    .iec(iec), .flush(flush), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pe;
    logic [4:0]  exc;
    logic [31:0] pc;
    logic        bd;
    logic        er;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [7:0]  hw;
    logic        f, s, r;
    logic [31:0] rpc;
    logic        ie;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    logic        f, s, r;
    logic [31:0] pc;
  } out_t;

  vec_t tbl[16];

  // Reference model: architectural registers plus a queue of per-cycle
  // control-output events scheduled by each accepted request.
  logic [5:0]  m_status;
  logic        m_bd;
  logic [1:0]  m_ip;
  logic [4:0]  m_exc;
  logic [31:0] m_epc;
  int          m_ignore;
  out_t        m_q[$];
  out_t        m_cur;

  function automatic vec_t mk(input logic pe, input logic [4:0] exc, input logic [31:0] pc,
                              input logic bd, input logic er, input logic we,
                              input logic [4:0] addr, input logic [31:0] wd, input logic [7:0] hw,
                              input logic f, input logic s, input logic r, input logic [31:0] rpc,
                              input logic ie, input logic [31:0] rd);
    vec_t v;
    v.pe = pe; v.exc = exc; v.pc = pc; v.bd = bd; v.er = er; v.we = we;
    v.addr = addr; v.wd = wd; v.hw = hw; v.f = f; v.s = s; v.r = r;
    v.rpc = rpc; v.ie = ie; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    pendingexception = 0; exccode = 0; ex_pc = 0; ex_bd = 0; eret = 0;
    mtc0_we = 0; cp0_addr = 0; cp0_wdata = 0; hw_int = 0;
  endtask

  task automatic model_reset();
    m_status = 0; m_bd = 0; m_ip = 0; m_exc = 0; m_epc = 0; m_ignore = 0;
    m_q.delete();
    m_cur = '{1'b0, 1'b0, 1'b0, 32'd0};
  endtask

  task automatic model_edge();
    out_t e;
    if (m_ignore > 0) begin
      m_ignore--;
    end else if (pendingexception) begin
      m_epc    = ex_bd ? ex_pc - 32'd4 : ex_pc;
      m_bd     = ex_bd;
      m_exc    = exccode;
      m_status = {m_status[3:0], 2'b00};
      m_ignore = 2;
      e = '{1'b1, 1'b1, 1'b0, 32'd0};          m_q.push_back(e);
      e = '{1'b0, 1'b1, 1'b1, 32'h8000_0080};  m_q.push_back(e);
    end else begin
      if (eret) begin
        e = '{1'b1, 1'b0, 1'b1, m_epc};
        m_q.push_back(e);
        m_status = {m_status[5:4], m_status[5:2]};
      end
      if (mtc0_we) begin
        if (cp0_addr == 5'd12 && !eret) m_status = cp0_wdata[5:0];
        if (cp0_addr == 5'd13) m_ip = cp0_wdata[9:8];
        if (cp0_addr == 5'd14) m_epc = cp0_wdata;
      end
    end
    if (m_q.size() > 0) m_cur = m_q.pop_front();
    else m_cur = '{1'b0, 1'b0, 1'b0, 32'd0};
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic [7:0] hw);
    logic [31:0] v;
    v = 32'd0;
    if (a == 5'd12) v[5:0] = m_status;
    if (a == 5'd13) begin
      v[31] = m_bd; v[15:10] = hw[7:2]; v[9:8] = m_ip; v[6:2] = m_exc;
    end
    if (a == 5'd14) v = m_epc;
    return v;
  endfunction

  task automatic model_tick(input int cyc);
    @(posedge clk);
    model_edge();
    #1;
    chk($sformatf("rnd%0d flush", cyc), {31'd0, flush}, {31'd0, m_cur.f});
    chk($sformatf("rnd%0d stall", cyc), {31'd0, stall}, {31'd0, m_cur.s});
    chk($sformatf("rnd%0d redirect", cyc), {31'd0, redirect}, {31'd0, m_cur.r});
    chk($sformatf("rnd%0d redirect_pc", cyc), redirect_pc, m_cur.pc);
    chk($sformatf("rnd%0d iec", cyc), {31'd0, iec}, {31'd0, m_status[0]});
    chk($sformatf("rnd%0d rdata", cyc), cp0_rdata, model_read(cp0_addr, hw_int));
  endtask

  initial begin
    // Directed table: inputs applied for one edge, outputs checked after it.
    tbl[0]  = mk(0, 0, 0, 0, 0, 1, 12, 32'h1, 0,            0, 0, 0, 0,            1, 32'h1);
    tbl[1]  = mk(1, 8, 32'h400, 0, 0, 0, 14, 0, 0,          1, 1, 0, 0,            0, 32'h400);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 13, 0, 0,                0, 1, 1, 32'h8000_0080, 0, 32'h20);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 12, 0, 0,                0, 0, 0, 0,            0, 32'h4);
    tbl[4]  = mk(0, 0, 0, 0, 1, 0, 12, 0, 0,                1, 0, 1, 32'h400,      1, 32'h1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 14, 0, 0,                0, 0, 0, 0,            1, 32'h400);
    tbl[6]  = mk(1, 4, 32'h1004, 1, 0, 0, 14, 0, 0,         1, 1, 0, 0,            0, 32'h1000);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 13, 0, 0,                0, 1, 1, 32'h8000_0080, 0, 32'h8000_0010);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0,            0, 32'h0);
    tbl[9]  = mk(1, 12, 32'h2000, 0, 1, 1, 12, 32'h3F, 0,   1, 1, 0, 0,            0, 32'h10);
    tbl[10] = mk(1, 3, 32'h3000, 0, 1, 1, 13, 32'hFFFF_FFFF, 0, 0, 1, 1, 32'h8000_0080, 0, 32'h30);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 14, 0, 0,                0, 0, 0, 0,            0, 32'h2000);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 13, 0, 8'hA5,            0, 0, 0, 0,            0, 32'hA430);
    tbl[13] = mk(0, 0, 0, 0, 0, 1, 13, 32'hFFFF_FFFF, 0,    0, 0, 0, 0,            0, 32'h330);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 14, 32'h1234_5678, 0,    0, 0, 0, 0,            0, 32'h1234_5678);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 5, 32'h1, 0,             0, 0, 0, 0,            0, 32'h0);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cp0_addr = 5'd12;
    #1;
    chk("reset flush", {31'd0, flush}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset redirect", {31'd0, redirect}, 32'd0);
    chk("reset redirect_pc", redirect_pc, 32'd0);
    chk("reset iec", {31'd0, iec}, 32'd0);
    chk("reset status", cp0_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      pendingexception = tbl[i].pe; exccode = tbl[i].exc; ex_pc = tbl[i].pc;
      ex_bd = tbl[i].bd; eret = tbl[i].er; mtc0_we = tbl[i].we;
      cp0_addr = tbl[i].addr; cp0_wdata = tbl[i].wd; hw_int = tbl[i].hw;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d flush", i), {31'd0, flush}, {31'd0, tbl[i].f});
      chk($sformatf("row%0d stall", i), {31'd0, stall}, {31'd0, tbl[i].s});
      chk($sformatf("row%0d redirect", i), {31'd0, redirect}, {31'd0, tbl[i].r});
      chk($sformatf("row%0d redirect_pc", i), redirect_pc, tbl[i].rpc);
      chk($sformatf("row%0d iec", i), {31'd0, iec}, {31'd0, tbl[i].ie});
      chk($sformatf("row%0d rdata", i), cp0_rdata, tbl[i].rd);
      $display("row %0d: pe=%0b eret=%0b we=%0b addr=%0d -> flush=%0b stall=%0b redirect=%0b pc=%h rdata=%h",
               i, tbl[i].pe, tbl[i].er, tbl[i].we, tbl[i].addr, flush, stall, redirect, redirect_pc, cp0_rdata);
    end

    // Reset landing in FLUSH must abort the sequence immediately.
    idle_inputs();
    pendingexception = 1; exccode = 5'd2; ex_pc = 32'h500;
    @(posedge clk);
    #1;
    chk("abort in_flush", {31'd0, flush}, 32'd1);
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("abort flush", {31'd0, flush}, 32'd0);
    chk("abort stall", {31'd0, stall}, 32'd0);
    chk("abort redirect", {31'd0, redirect}, 32'd0);
    chk("abort redirect_pc", redirect_pc, 32'd0);
    chk("abort iec", {31'd0, iec}, 32'd0);
    cp0_addr = 5'd12;
    #1;
    chk("abort status", cp0_rdata, 32'd0);
    cp0_addr = 5'd14;
    #1;
    chk("abort epc", cp0_rdata, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_abort%0d redirect", k), {31'd0, redirect}, 32'd0);
      chk($sformatf("post_abort%0d flush", k), {31'd0, flush}, 32'd0);
      chk($sformatf("post_abort%0d stall", k), {31'd0, stall}, 32'd0);
      $display("post-abort cycle %0d: flush=%0b stall=%0b redirect=%0b", k, flush, stall, redirect);
    end

    // Randomized traffic against the reference model.
    model_reset();
    for (int c = 0; c < 400; c++) begin
      pendingexception = ($urandom_range(99) < 15);
      eret             = ($urandom_range(99) < 15);
      mtc0_we          = ($urandom_range(99) < 35);
      if (eret && mtc0_we && !pendingexception) mtc0_we = 1'b0;
      exccode   = 5'($urandom);
      ex_pc     = $urandom;
      ex_bd     = 1'($urandom);
      hw_int    = 8'($urandom);
      cp0_wdata = $urandom;
      case ($urandom_range(4))
        0:       cp0_addr = 5'd12;
        1:       cp0_addr = 5'd13;
        2:       cp0_addr = 5'd14;
        default: cp0_addr = 5'($urandom);
      endcase
      model_tick(c);
      if (c % 50 == 0)
        $display("random cycle %0d: flush=%0b stall=%0b redirect=%0b pc=%h", c, flush, stall, redirect, redirect_pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
